// File: rtl/user_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// user_write_arbiter_if
//
// Purpose:
//   Bundles the request side, the forwarded-write side and the access-denied
//   reporting signals of the user write arbiter into one interface.
//
// Parameters:
//   ID_W    requester ID width; NUM_USERS = 2**ID_W
//   DATA_W  write data width
//   CNT_W   width of the saturating deny counter
//
// Signals:
//   req_valid    NUM_USERS         per-requester write request
//   req_data     NUM_USERS*DATA_W  packed data; user i at [i*DATA_W +: DATA_W]
//   req_ready    NUM_USERS         one-hot accept from the arbiter
//   out_valid    1                 forwarded write valid
//   out_ready    1                 downstream accept
//   out_usr_id   ID_W              ID of the forwarded write
//   out_data     DATA_W            forwarded write data
//   deny_pulse   1                 one-cycle strobe per denied request
//   deny_usr_id  ID_W              ID of the last denied request
//   deny_count   CNT_W             saturating count of denied requests
//
// Modports:
//   slave   the arbiter itself (serves the requesters, drives the outputs)
//   master  the surrounding environment (requesters plus downstream sink)
// ----------------------------------------------------------------------------
interface user_write_arbiter_if #(
    parameter int ID_W   = 2,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    localparam int NUM_USERS = 2 ** ID_W;

    logic [NUM_USERS-1:0]        req_valid;
    logic [NUM_USERS*DATA_W-1:0] req_data;
    logic [NUM_USERS-1:0]        req_ready;

    logic                        out_valid;
    logic                        out_ready;
    logic [ID_W-1:0]             out_usr_id;
    logic [DATA_W-1:0]           out_data;

    logic                        deny_pulse;
    logic [ID_W-1:0]             deny_usr_id;
    logic [CNT_W-1:0]            deny_count;

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output out_valid,
        input  out_ready,
        output out_usr_id,
        output out_data,
        output deny_pulse,
        output deny_usr_id,
        output deny_count
    );

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  out_valid,
        output out_ready,
        input  out_usr_id,
        input  out_data,
        input  deny_pulse,
        input  deny_usr_id,
        input  deny_count
    );
endinterface

// File: rtl/user_write_arbiter.sv
// ----------------------------------------------------------------------------
// user_write_arbiter
//
// Purpose:
//   Upstream feeder for the user-locked register stage. Collects write
//   requests from NUM_USERS requesters and accepts one at a time in
//   round-robin order. A request from ALLOWED_ID is forwarded over a
//   valid/ready port to the locked register; a request from any other ID is
//   consumed, dropped and reported as an access-denied event, so the
//   downstream register only ever sees the permitted ID.
//
// Parameters:
//   ID_W        requester ID width; NUM_USERS = 2**ID_W
//   DATA_W      write data width
//   ALLOWED_ID  the only ID whose writes are forwarded
//   CNT_W       width of the saturating deny counter
//
// Ports:
//   clk   in   clock, all logic on the rising edge
//   rst   in   synchronous, active-high reset
//   bus   slave side of user_write_arbiter_if:
//           req_valid/req_data in, req_ready out (combinational, one-hot)
//           out_valid/out_usr_id/out_data out, out_ready in
//           deny_pulse/deny_usr_id/deny_count out
//
// Operation:
//   IDLE  : pick the first requester at or after ptr, accept it this cycle,
//           capture its data and move to ISSUE (allowed) or DENY (other).
//   ISSUE : hold the forwarded write until the downstream accepts it.
//   DENY  : one-cycle deny strobe, then back to IDLE.
//   A request therefore occupies at least two cycles.
// ----------------------------------------------------------------------------
module user_write_arbiter #(
    parameter int ID_W       = 2,
    parameter int DATA_W     = 8,
    parameter int ALLOWED_ID = 2,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    user_write_arbiter_if.slave  bus
);
    localparam int              NUM_USERS = 2 ** ID_W;
    localparam logic [ID_W-1:0] ALLOWED   = ID_W'(ALLOWED_ID);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [NUM_USERS-1:0] ONE_HOT_BASE = {{(NUM_USERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DENY  = 2'd2
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     ptr;

    logic                grant_any;
    logic [ID_W-1:0]     grant_id;
    logic [DATA_W-1:0]   grant_data;
    logic [NUM_USERS-1:0] grant_onehot;

    logic                out_valid_q;
    logic [ID_W-1:0]     out_usr_id_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                deny_pulse_q;
    logic [ID_W-1:0]     deny_usr_id_q;
    logic [CNT_W-1:0]    deny_count_q;

    // Round-robin search. Because NUM_USERS is a power of two, adding the
    // offset to ptr in ID_W bits wraps naturally, which gives the modulo
    // walk ptr, ptr+1, ... without any explicit compare.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = ptr;
        for (int k = 0; k < NUM_USERS; k++) begin
            if (!grant_any && bus.req_valid[ptr + ID_W'(k)]) begin
                grant_any = 1'b1;
                grant_id  = ptr + ID_W'(k);
            end
        end
    end

    assign grant_data = bus.req_data[int'(grant_id) * DATA_W +: DATA_W];

    // Accept is only offered while idle and out of reset, so a requester can
    // never see a handshake for a transaction that reset would throw away.
    always_comb begin
        grant_onehot = '0;
        if (!rst && (state == IDLE) && grant_any) begin
            grant_onehot = ONE_HOT_BASE << grant_id;
        end
    end

    // Main FSM with all outputs registered. deny_pulse defaults low every
    // cycle so it can only be high in the single DENY cycle. out_data,
    // out_usr_id and deny_usr_id keep their last value when not refreshed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            out_valid_q   <= 1'b0;
            out_usr_id_q  <= '0;
            out_data_q    <= '0;
            deny_pulse_q  <= 1'b0;
            deny_usr_id_q <= '0;
            deny_count_q  <= '0;
        end else begin
            deny_pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        ptr <= grant_id + ID_W'(1);
                        if (grant_id == ALLOWED) begin
                            state        <= ISSUE;
                            out_valid_q  <= 1'b1;
                            out_usr_id_q <= grant_id;
                            out_data_q   <= grant_data;
                        end else begin
                            state         <= DENY;
                            deny_pulse_q  <= 1'b1;
                            deny_usr_id_q <= grant_id;
                            if (deny_count_q != CNT_MAX) begin
                                deny_count_q <= deny_count_q + CNT_W'(1);
                            end
                        end
                    end
                end

                ISSUE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end

                DENY: begin
                    state <= IDLE;
                end

                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = grant_onehot;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_usr_id  = out_usr_id_q;
    assign bus.out_data    = out_data_q;
    assign bus.deny_pulse  = deny_pulse_q;
    assign bus.deny_usr_id = deny_usr_id_q;
    assign bus.deny_count  = deny_count_q;

    // Structural invariants of the accept and output sequencing.
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.req_ready));

    a_ready_idle_only: assert property (@(posedge clk) disable iff (rst)
        (state != IDLE) |-> (bus.req_ready == '0));

    a_valid_in_issue: assert property (@(posedge clk) disable iff (rst)
        bus.out_valid == (state == ISSUE));

    a_deny_in_deny: assert property (@(posedge clk) disable iff (rst)
        bus.deny_pulse == (state == DENY));

    a_forward_id: assert property (@(posedge clk) disable iff (rst)
        bus.out_valid |-> (bus.out_usr_id == ALLOWED));

endmodule
